// File: rtl/dmux8way16_router.sv
// dmux8way16_router: registered 8-way demultiplexer/router.
// One word per cycle is accepted on a valid/ready input and parked in the
// single-entry holding register of the channel chosen by SEL (0=A .. 7=H).
// Each channel drains through its own valid/ready handshake. A full channel
// can take a new word in the same cycle its current word is drained.
module dmux8way16_router #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN,
  input  logic [2:0]       SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [7:0]       OUT_VALID,
  input  logic [7:0]       OUT_READY,
  output logic [CNT_W-1:0] XFER_COUNT
);

  localparam int unsigned NUM_CH = 8;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  ch_state_e        ch_state_q [NUM_CH];
  ch_state_e        ch_state_d [NUM_CH];
  logic [WIDTH-1:0] ch_data_q  [NUM_CH];
  logic [NUM_CH-1:0] ch_load;
  logic [NUM_CH-1:0] ch_drain;
  logic              in_xfer;
  logic [CNT_W-1:0]  xfer_count_q;

  // Input ready depends only on the selected channel's occupancy and its sink;
  // it is held low during reset so nothing is taken while state is cleared.
  always_comb begin
    IN_READY = 1'b0;
    if (RST_N) begin
      IN_READY = ~OUT_VALID[SEL] | OUT_READY[SEL];
    end
  end

  assign in_xfer = IN_VALID & IN_READY;

  // Decode per-channel load (input transfer addressed to it) and drain events.
  always_comb begin
    ch_load  = '0;
    ch_drain = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_load[i]  = in_xfer && (SEL == 3'(i));
      ch_drain[i] = OUT_VALID[i] & OUT_READY[i];
    end
  end

  // Per-channel EMPTY/FULL next state: a load always leaves the channel full,
  // a drain without a load empties it, otherwise the state is held.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_state_d[i] = ch_state_q[i];
      case (ch_state_q[i])
        CH_EMPTY: begin
          if (ch_load[i]) ch_state_d[i] = CH_FULL;
        end
        CH_FULL: begin
          if (ch_drain[i] && !ch_load[i]) ch_state_d[i] = CH_EMPTY;
        end
        default: ch_state_d[i] = CH_EMPTY;
      endcase
    end
  end

  // Channel state registers; reset discards any held words.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= CH_EMPTY;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_state_q[i] <= ch_state_d[i];
      end
    end
  end

  // Channel data registers change only when their channel is loaded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_load[i]) ch_data_q[i] <= IN;
      end
    end
  end

  // Accepted-word counter, wraps modulo 2^CNT_W; drains do not touch it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      xfer_count_q <= '0;
    end else if (in_xfer) begin
      xfer_count_q <= xfer_count_q + CNT_W'(1);
    end
  end

  // Expose channel occupancy as the per-channel valid vector.
  always_comb begin
    OUT_VALID = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      OUT_VALID[i] = (ch_state_q[i] == CH_FULL);
    end
  end

  assign A          = ch_data_q[0];
  assign B          = ch_data_q[1];
  assign C          = ch_data_q[2];
  assign D          = ch_data_q[3];
  assign E          = ch_data_q[4];
  assign F          = ch_data_q[5];
  assign G          = ch_data_q[6];
  assign H          = ch_data_q[7];
  assign XFER_COUNT = xfer_count_q;

endmodule

// File: tb/tb_dmux8way16_router.sv
// Testbench for dmux8way16_router: directed vector table plus hand-written
// sequences for async reset, back-pressure, streaming and counter wrap.
module tb_dmux8way16_router;

  logic        CLK;
  logic        RST_N;
  logic [15:0] IN;
  logic [2:0]  SEL;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] A, B, C, D, E, F, G, H;
  logic [7:0]  OUT_VALID;
  logic [7:0]  OUT_READY;
  logic [15:0] XFER_COUNT;

  int unsigned n_total;
  int unsigned n_pass;

  dmux8way16_router #(.WIDTH(16), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IN         (IN),
    .SEL        (SEL),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .E          (E),
    .F          (F),
    .G          (G),
    .H          (H),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .XFER_COUNT (XFER_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] din;
    logic        vld;
    logic [7:0]  ordy;
    logic        exp_rdy;
    logic [7:0]  exp_ov;
    logic [15:0] exp_cnt;
    logic [15:0] exp_dat;   // expected data on channel 'sel' after the edge
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] ch_word(input logic [2:0] idx);
    case (idx)
      3'd0: return A;
      3'd1: return B;
      3'd2: return C;
      3'd3: return D;
      3'd4: return E;
      3'd5: return F;
      3'd6: return G;
      default: return H;
    endcase
  endfunction

  task automatic drive(input logic [2:0] sel, input logic [15:0] din,
                       input logic vld, input logic [7:0] ordy);
    @(negedge CLK);
    SEL = sel; IN = din; IN_VALID = vld; OUT_READY = ordy;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    RST_N = 1'b0; IN = '0; SEL = '0; IN_VALID = 1'b0; OUT_READY = '0;

    // Route all, then back-pressure, drains, drain+load, don't-care SEL/IN.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{sel: 3'(i), din: 16'(16'h1111 * (i + 1)), vld: 1'b1, ordy: 8'h00,
                  exp_rdy: 1'b1, exp_ov: 8'((1 << (i + 1)) - 1),
                  exp_cnt: 16'(i + 1), exp_dat: 16'(16'h1111 * (i + 1))};
    end
    vecs[8]  = '{3'd3, 16'h1234, 1'b1, 8'h00, 1'b0, 8'hFF, 16'd8,  16'h4444};
    vecs[9]  = '{3'd0, 16'hDEAD, 1'b0, 8'h01, 1'b1, 8'hFE, 16'd8,  16'h1111};
    vecs[10] = '{3'd0, 16'h0A0A, 1'b1, 8'h00, 1'b1, 8'hFF, 16'd9,  16'h0A0A};
    vecs[11] = '{3'd1, 16'h00BB, 1'b1, 8'h02, 1'b1, 8'hFF, 16'd10, 16'h00BB};
    vecs[12] = '{3'd7, 16'hFFFF, 1'b0, 8'hFF, 1'b1, 8'h00, 16'd10, 16'h8888};
    vecs[13] = '{3'd4, 16'h1234, 1'b1, 8'h00, 1'b1, 8'h10, 16'd11, 16'h1234};
    vecs[14] = '{3'd6, 16'hC0DE, 1'b1, 8'h10, 1'b1, 8'h40, 16'd12, 16'hC0DE};
    vecs[15] = '{3'd6, 16'h5A5A, 1'b0, 8'h00, 1'b0, 8'h40, 16'd12, 16'hC0DE};

    // Reset state while RST_N is held low.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(OUT_VALID), 32'h00);
    chk("rst_count", 32'(XFER_COUNT), 32'h0);
    chk("rst_in_ready", 32'(IN_READY), 32'h0);
    chk("rst_a", 32'(A), 32'h0);
    chk("rst_h", 32'(H), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].sel, vecs[i].din, vecs[i].vld, vecs[i].ordy);
      chk($sformatf("v%0d_in_ready", i), 32'(IN_READY), 32'(vecs[i].exp_rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(OUT_VALID), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_count", i), 32'(XFER_COUNT), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_data", i), 32'(ch_word(vecs[i].sel)), 32'(vecs[i].exp_dat));
    end

    // Asynchronous reset mid-stream with C full.
    drive(3'd2, 16'h5555, 1'b1, 8'h00);
    @(posedge CLK);
    #1;
    chk("pre_rst_c", 32'(C), 32'h5555);
    chk("pre_rst_out_valid", 32'(OUT_VALID), 32'h44);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(OUT_VALID), 32'h00);
    chk("async_rst_c", 32'(C), 32'h0000);
    chk("async_rst_count", 32'(XFER_COUNT), 32'h0);
    chk("async_rst_in_ready", 32'(IN_READY), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    IN_VALID = 1'b0;

    // Back-pressure on D, then retarget to E in the same cycle.
    drive(3'd3, 16'hBEEF, 1'b1, 8'h00);
    @(posedge CLK);
    drive(3'd3, 16'h1234, 1'b1, 8'h00);
    chk("bp_d_in_ready", 32'(IN_READY), 32'h0);
    SEL = 3'd4;
    #1;
    chk("bp_e_in_ready", 32'(IN_READY), 32'h1);
    @(posedge CLK);
    #1;
    chk("bp_d_data", 32'(D), 32'hBEEF);
    chk("bp_e_data", 32'(E), 32'h1234);
    chk("bp_out_valid", 32'(OUT_VALID), 32'h18);
    chk("bp_count", 32'(XFER_COUNT), 32'd2);

    // Streaming 100 words into F with its sink always ready.
    for (int k = 0; k < 100; k++) begin
      drive(3'd5, 16'(16'hA000 + k), 1'b1, 8'h20);
      chk($sformatf("stream%0d_in_ready", k), 32'(IN_READY), 32'h1);
      @(posedge CLK);
      #1;
      chk($sformatf("stream%0d_f", k), 32'(F), 32'(16'hA000 + k));
      chk($sformatf("stream%0d_valid_f", k), 32'(OUT_VALID[5]), 32'h1);
    end
    chk("stream_count", 32'(XFER_COUNT), 32'd102);

    // Counter wrap: bring the count to 0xFFFF, then one more transfer.
    drive(3'd0, 16'h0F0F, 1'b1, 8'hFF);
    repeat (65433) @(posedge CLK);
    #1;
    chk("count_max", 32'(XFER_COUNT), 32'hFFFF);
    @(posedge CLK);
    #1;
    chk("count_wrap", 32'(XFER_COUNT), 32'h0000);
    drive(3'd0, 16'h0000, 1'b0, 8'hFF);
    @(posedge CLK);
    #1;
    chk("count_idle_hold", 32'(XFER_COUNT), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
